multi_player_timer: RTL and testbench



---
 rtl/multi_player_timer_if.sv | 33 +++
 rtl/multi_player_timer.sv | 205 ++++++++++++++++++++
 tb/tb_multi_player_timer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_player_timer_if.sv
// multi_player_timer_if: control and display bundle between the game FSM,
// the multi-player timer and the FND display mux.
interface multi_player_timer_if #(
  parameter int NUM_PLAYERS = 2
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic                   start;
  logic                   play_en;
  logic                   turn_next;
  logic                   game_final;
  logic                   restart;
  logic [PW-1:0]          player_id;
  logic [3:0]             sec0;
  logic [3:0]             sec1;
  logic [3:0]             min0;
  logic [3:0]             min1;
  logic [NUM_PLAYERS-1:0] time_over;
  logic                   game_end;
  logic                   tick;

  modport master (
    output start, play_en, turn_next, game_final, restart,
    input  player_id, sec0, sec1, min0, min1,
    input  time_over, game_end, tick
  );

  modport slave (
    input  start, play_en, turn_next, game_final, restart,
    output player_id, sec0, sec1, min0, min1,
    output time_over, game_end, tick
  );
endinterface

// File: rtl/multi_player_timer.sv
// multi_player_timer: per-player mm:ss BCD chess clock with turn hand-over.
// Define TIMER_BONUS_EN to add BONUS_SEC to the outgoing clock on turn_next.
module multi_player_timer #(
  parameter int NUM_PLAYERS = 2,
  parameter int TICK_DIV    = 100_000_000,
  parameter int INIT_MIN    = 10,
  parameter int INIT_SEC    = 0,
  parameter int BONUS_SEC   = 5
) (
  input logic clk,
  input logic rst_n,
  multi_player_timer_if.slave bus
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [15:0] INIT_BCD = {
    4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
    4'(INIT_SEC / 10), 4'(INIT_SEC % 10)
  };

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_STOP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  if (INIT_MIN * 60 + INIT_SEC == 0 || BONUS_SEC > 59
      || TICK_DIV < 2) begin : g_bad_cfg
    $error("multi_player_timer: illegal parameter set");
  end

  logic [1:0]             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   tick, tick_nxt;
  logic                   chk, chk_nxt;
  logic [PW-1:0]          pid, pid_nxt;
  logic [NUM_PLAYERS-1:0] tov, tov_nxt;
  logic [15:0]            ch [NUM_PLAYERS];
  logic [15:0]            ch_nxt [NUM_PLAYERS];
  logic [15:0]            dig;
  logic [15:0]            cur, upd;
  logic                   expire;

  function automatic logic [15:0] dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // First non-expired player after p, cyclically; p itself if none.
  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p,
    input logic [NUM_PLAYERS-1:0] x
  );
    logic [PW-1:0] r;
    logic          found;
    int            idx;
    r = p;
    found = 1'b0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      idx = (int'(p) + i) % NUM_PLAYERS;
      if (!found && !x[idx]) begin
        r = PW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef TIMER_BONUS_EN
  function automatic logic [15:0] add_bonus(input logic [15:0] v);
    logic [6:0]  s, m;
    logic [15:0] r;
    s = 7'(v[7:4]) * 7'd10 + 7'(v[3:0]) + 7'(BONUS_SEC);
    m = 7'(v[15:12]) * 7'd10 + 7'(v[11:8]);
    if (s >= 7'd60) begin
      s = s - 7'd60;
      m = m + 7'd1;
    end
    r = {4'(m / 7'd10), 4'(m % 7'd10), 4'(s / 7'd10), 4'(s % 7'd10)};
    if (m > 7'd99) r = 16'h9959;
    return r;
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tick_nxt  = 1'b0;
    chk_nxt   = 1'b0;
    pid_nxt   = pid;
    tov_nxt   = tov;
    for (int i = 0; i < NUM_PLAYERS; i++) ch_nxt[i] = ch[i];
    cur    = ch[pid];
    upd    = cur;
    expire = 1'b0;
    unique case (state)
      S_INIT: begin
        for (int i = 0; i < NUM_PLAYERS; i++) ch_nxt[i] = INIT_BCD;
        tov_nxt = '0;
        pid_nxt = '0;
        cnt_nxt = '0;
        if (bus.start) state_nxt = S_STOP;
      end
      S_END: begin
        if (bus.restart) begin
          for (int i = 0; i < NUM_PLAYERS; i++) ch_nxt[i] = INIT_BCD;
          tov_nxt   = '0;
          pid_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_INIT;
        end
      end
      S_STOP, S_RUN: begin
        if (state == S_RUN && bus.game_final) begin
          state_nxt = S_END;
        end else if (chk) begin
          // Cycle after an expiry: end the game or skip to a live player.
          if ($countones(~tov) <= 1) state_nxt = S_END;
          else begin
            pid_nxt = nxt(pid, tov);
            cnt_nxt = '0;
          end
        end else begin
          if (tick && !tov[pid]) begin
            upd    = dec(cur);
            expire = (cur == 16'h0001);
          end
          if (bus.play_en) begin
            if (cnt == CNT_MAX) begin
              cnt_nxt  = '0;
              tick_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          if (state == S_STOP) begin
            if (bus.play_en) state_nxt = S_RUN;
          end else if (expire) begin
            tov_nxt[pid] = 1'b1;
            chk_nxt      = 1'b1;
          end else if (bus.turn_next) begin
`ifdef TIMER_BONUS_EN
            upd = add_bonus(upd);
`endif
            pid_nxt  = nxt(pid, tov);
            cnt_nxt  = '0;
            tick_nxt = 1'b0;
          end else if (!bus.play_en) begin
            state_nxt = S_STOP;
          end
          if (state == S_STOP && expire) begin
            tov_nxt[pid] = 1'b1;
            chk_nxt      = 1'b1;
          end
          ch_nxt[pid] = upd;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
      tick  <= 1'b0;
      chk   <= 1'b0;
      pid   <= '0;
      tov   <= '0;
      dig   <= INIT_BCD;
      for (int i = 0; i < NUM_PLAYERS; i++) ch[i] <= INIT_BCD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tick  <= tick_nxt;
      chk   <= chk_nxt;
      pid   <= pid_nxt;
      tov   <= tov_nxt;
      dig   <= ch_nxt[pid_nxt];
      for (int i = 0; i < NUM_PLAYERS; i++) ch[i] <= ch_nxt[i];
    end
  end

  assign bus.player_id = pid;
  assign bus.min1      = dig[15:12];
  assign bus.min0      = dig[11:8];
  assign bus.sec1      = dig[7:4];
  assign bus.sec0      = dig[3:0];
  assign bus.time_over = tov;
  assign bus.game_end  = (state == S_END);
  assign bus.tick      = tick;
endmodule

// File: tb/tb_multi_player_timer.sv
// tb_multi_player_timer: four timer configurations driven from one vector
// table plus hand-written expiry and reset sequences.
module tb_multi_player_timer;
`ifdef TIMER_BONUS_EN
  localparam bit BON = 1'b1;
`else
  localparam bit BON = 1'b0;
`endif
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] ST = 5'b10000;
  localparam logic [4:0] PE = 5'b01000;
  localparam logic [4:0] TN = 5'b00100;
  localparam logic [4:0] GF = 5'b00010;
  localparam logic [4:0] RS = 5'b00001;

  logic clk;
  logic rst_n;
  logic st [4];
  logic pe [4];
  logic tn [4];
  logic gf [4];
  logic rs [4];
  logic [15:0] dg [4];
  logic [2:0]  pid_o [4];
  logic [7:0]  to_o [4];
  logic        tk [4];
  logic        ge_o [4];

  typedef struct {
    string       name;
    int          k;
    logic [4:0]  ctl;
    int          n;
    logic [15:0] dig;
    logic [2:0]  pid;
    logic        tick;
    logic        ge;
    logic [7:0]  to;
  } vec_t;

  vec_t tbl [$];
  vec_t exp_q [$];
  int n_chk;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multi_player_timer_if #(.NUM_PLAYERS(2)) ifa ();
  multi_player_timer_if #(.NUM_PLAYERS(3)) ifb ();
  multi_player_timer_if #(.NUM_PLAYERS(2)) ifc ();
  multi_player_timer_if #(.NUM_PLAYERS(2)) ifd ();

  multi_player_timer #(
    .NUM_PLAYERS(2), .TICK_DIV(10), .INIT_MIN(10), .INIT_SEC(0), .BONUS_SEC(5)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  multi_player_timer #(
    .NUM_PLAYERS(3), .TICK_DIV(10), .INIT_MIN(0), .INIT_SEC(2), .BONUS_SEC(5)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  multi_player_timer #(
    .NUM_PLAYERS(2), .TICK_DIV(10), .INIT_MIN(5), .INIT_SEC(0), .BONUS_SEC(5)
  ) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
  multi_player_timer #(
    .NUM_PLAYERS(2), .TICK_DIV(10), .INIT_MIN(99), .INIT_SEC(58), .BONUS_SEC(5)
  ) u_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

  assign {ifa.start, ifa.play_en, ifa.turn_next} = {st[0], pe[0], tn[0]};
  assign {ifa.game_final, ifa.restart} = {gf[0], rs[0]};
  assign {ifb.start, ifb.play_en, ifb.turn_next} = {st[1], pe[1], tn[1]};
  assign {ifb.game_final, ifb.restart} = {gf[1], rs[1]};
  assign {ifc.start, ifc.play_en, ifc.turn_next} = {st[2], pe[2], tn[2]};
  assign {ifc.game_final, ifc.restart} = {gf[2], rs[2]};
  assign {ifd.start, ifd.play_en, ifd.turn_next} = {st[3], pe[3], tn[3]};
  assign {ifd.game_final, ifd.restart} = {gf[3], rs[3]};

  assign dg[0] = {ifa.min1, ifa.min0, ifa.sec1, ifa.sec0};
  assign dg[1] = {ifb.min1, ifb.min0, ifb.sec1, ifb.sec0};
  assign dg[2] = {ifc.min1, ifc.min0, ifc.sec1, ifc.sec0};
  assign dg[3] = {ifd.min1, ifd.min0, ifd.sec1, ifd.sec0};
  assign pid_o[0] = 3'(ifa.player_id);
  assign pid_o[1] = 3'(ifb.player_id);
  assign pid_o[2] = 3'(ifc.player_id);
  assign pid_o[3] = 3'(ifd.player_id);
  assign to_o[0] = 8'(ifa.time_over);
  assign to_o[1] = 8'(ifb.time_over);
  assign to_o[2] = 8'(ifc.time_over);
  assign to_o[3] = 8'(ifd.time_over);
  assign {tk[0], ge_o[0]} = {ifa.tick, ifa.game_end};
  assign {tk[1], ge_o[1]} = {ifb.tick, ifb.game_end};
  assign {tk[2], ge_o[2]} = {ifc.tick, ifc.game_end};
  assign {tk[3], ge_o[3]} = {ifd.tick, ifd.game_end};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endtask

  task automatic add(input string nm, input int k, input logic [4:0] ctl,
                     input int n, input logic [15:0] dig,
                     input logic [2:0] pid, input logic tick,
                     input logic ge, input logic [7:0] to);
    vec_t v;
    v.name = nm; v.k = k; v.ctl = ctl; v.n = n;
    v.dig = dig; v.pid = pid; v.tick = tick; v.ge = ge; v.to = to;
    tbl.push_back(v);
  endtask

  task automatic check(input vec_t e);
    cmp({e.name, ".dig"}, 32'(dg[e.k]), 32'(e.dig));
    cmp({e.name, ".pid"}, 32'(pid_o[e.k]), 32'(e.pid));
    cmp({e.name, ".tick"}, 32'(tk[e.k]), 32'(e.tick));
    cmp({e.name, ".game_end"}, 32'(ge_o[e.k]), 32'(e.ge));
    cmp({e.name, ".time_over"}, 32'(to_o[e.k]), 32'(e.to));
  endtask

  task automatic expect_now(input string nm, input int k,
                            input logic [15:0] dig, input logic [2:0] pid,
                            input logic tick, input logic ge,
                            input logic [7:0] to);
    vec_t v;
    v.name = nm; v.k = k; v.ctl = NO; v.n = 0;
    v.dig = dig; v.pid = pid; v.tick = tick; v.ge = ge; v.to = to;
    exp_q.push_back(v);
    check(exp_q.pop_front());
  endtask

  initial begin
    vec_t r;
    int e1, e2, seen;
    logic [15:0] init_d [4];
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st[i] = 0; pe[i] = 0; tn[i] = 0; gf[i] = 0; rs[i] = 0;
    end
    init_d[0] = 16'h1000; init_d[1] = 16'h0002;
    init_d[2] = 16'h0500; init_d[3] = 16'h9958;

    // Instance 0: 2 players, 10:00
    add("a_init",    0, NO,      1,  16'h1000, 0, 0, 0, 0);
    add("a_start",   0, ST,      1,  16'h1000, 0, 0, 0, 0);
    add("a_run9",    0, PE,      9,  16'h1000, 0, 0, 0, 0);
    add("a_tick1",   0, PE,      1,  16'h1000, 0, 1, 0, 0);
    add("a_dec1",    0, PE,      1,  16'h0959, 0, 0, 0, 0);
    add("a_to_p4",   0, PE,      3,  16'h0959, 0, 0, 0, 0);
    add("a_pause",   0, NO,      50, 16'h0959, 0, 0, 0, 0);
    add("a_resume5", 0, PE,      5,  16'h0959, 0, 0, 0, 0);
    add("a_tick2",   0, PE,      1,  16'h0959, 0, 1, 0, 0);
    add("a_dec2",    0, PE,      1,  16'h0958, 0, 0, 0, 0);
    add("a_run8",    0, PE,      8,  16'h0958, 0, 0, 0, 0);
    add("a_tick3",   0, PE,      1,  16'h0958, 0, 1, 0, 0);
    add("a_dec3",    0, PE,      1,  16'h0957, 0, 0, 0, 0);
    add("a_turn",    0, PE | TN, 1,  16'h1000, 1, 0, 0, 0);
    add("a_back",    0, PE | TN, 1,  BON ? 16'h1002 : 16'h0957, 0, 0, 0, 0);
    add("a_final",   0, PE | GF, 1,  BON ? 16'h1002 : 16'h0957, 0, 0, 1, 0);
    add("a_frozen",  0, PE,      12, BON ? 16'h1002 : 16'h0957, 0, 0, 1, 0);
    add("a_tn_ign",  0, PE | TN, 1,  BON ? 16'h1002 : 16'h0957, 0, 0, 1, 0);
    add("a_restart", 0, PE | RS, 1,  16'h1000, 0, 0, 0, 0);
    add("a_start2",  0, PE | ST, 1,  16'h1000, 0, 0, 0, 0);
    add("a_run2",    0, PE,      1,  16'h1000, 0, 0, 0, 0);
    add("a_turn2",   0, PE | TN, 1,  16'h1000, 1, 0, 0, 0);
    // Instance 2: tick and turn_next in the same cycle at 05:00
    add("c_start",   2, ST,      1,  16'h0500, 0, 0, 0, 0);
    add("c_run9",    2, PE,      9,  16'h0500, 0, 0, 0, 0);
    add("c_tick",    2, PE,      1,  16'h0500, 0, 1, 0, 0);
    add("c_tk_turn", 2, PE | TN, 1,  16'h0500, 1, 0, 0, 0);
    add("c_run9b",   2, PE,      9,  16'h0500, 1, 0, 0, 0);
    add("c_tick2",   2, PE,      1,  16'h0500, 1, 1, 0, 0);
    add("c_tk_back", 2, PE | TN, 1,  BON ? 16'h0504 : 16'h0459, 0, 0, 0, 0);
    // Instance 3: bonus saturation from 99:58
    add("d_start",   3, ST,      1,  16'h9958, 0, 0, 0, 0);
    add("d_run",     3, PE,      1,  16'h9958, 0, 0, 0, 0);
    add("d_turn",    3, PE | TN, 1,  16'h9958, 1, 0, 0, 0);
    add("d_back",    3, PE | TN, 1,  BON ? 16'h9959 : 16'h9958, 0, 0, 0, 0);
    // Instance 1: 3 players at 00:02, expiry and skip
    add("b_start",   1, ST,      1,  16'h0002, 0, 0, 0, 0);
    add("b_run9",    1, PE,      9,  16'h0002, 0, 0, 0, 0);
    add("b_tick1",   1, PE,      1,  16'h0002, 0, 1, 0, 0);
    add("b_dec1",    1, PE,      1,  16'h0001, 0, 0, 0, 0);
    add("b_run8",    1, PE,      8,  16'h0001, 0, 0, 0, 0);
    add("b_tick2",   1, PE,      1,  16'h0001, 0, 1, 0, 0);
    add("b_expire",  1, PE,      1,  16'h0000, 0, 0, 0, 8'h01);
    add("b_handov",  1, PE,      1,  16'h0002, 1, 0, 0, 8'h01);
    add("b_turn",    1, PE | TN, 1,  16'h0002, 2, 0, 0, 8'h01);
    add("b_skip",    1, PE | TN, 1,  BON ? 16'h0007 : 16'h0002, 1, 0, 0, 8'h01);

    step(1);
    for (int k = 0; k < 4; k++)
      expect_now($sformatf("reset%0d", k), k, init_d[k], 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      r = tbl[i];
      {st[r.k], pe[r.k], tn[r.k], gf[r.k], rs[r.k]} = r.ctl;
      exp_q.push_back(r);
      step(1);
      st[r.k] = 0; tn[r.k] = 0; gf[r.k] = 0; rs[r.k] = 0;
      if (r.n > 1) step(r.n - 1);
      check(exp_q.pop_front());
    end

    // Player 1 of instance 1 runs out; only player 2 is left alive.
    e1 = -1;
    e2 = -1;
    for (int c = 0; c < 300 && e2 < 0; c++) begin
      step(1);
      if (e1 < 0 && to_o[1][1]) e1 = c;
      if (ge_o[1]) e2 = c;
    end
    cmp("b_end_seen", 32'(e2 >= 0), 1);
    cmp("b_end_latency", 32'(e2 - e1), 1);
    expect_now("b_final", 1, 16'h0000, 1, 0, 1, 8'h03);
    step(5);
    expect_now("b_frozen", 1, 16'h0000, 1, 0, 1, 8'h03);

    // Asynchronous reset while instance 0 holds a tick pulse.
    seen = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      step(1);
      if (tk[0]) seen = 1;
    end
    cmp("a_tick_seen", 32'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    expect_now("a_async_rst", 0, 16'h1000, 0, 0, 0, 0);
    expect_now("b_async_rst", 1, 16'h0002, 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    expect_now("a_post_rst", 0, 16'h1000, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
